// File: rtl/semaforo_pkg.sv
// Shared definitions for the traffic-light bus monitor: phase/error codes, lamp indices, patterns.
package semaforo_pkg;

    localparam int unsigned LUZ_W  = 5;
    localparam int unsigned FASE_W = 3;
    localparam int unsigned ERRO_W = 3;

    // Lamp bit positions on the light bus
    localparam int unsigned CARRO_VERM  = 4;
    localparam int unsigned CARRO_AMAR  = 3;
    localparam int unsigned CARRO_VERDE = 2;
    localparam int unsigned PED_VERM    = 1;
    localparam int unsigned PED_VERDE   = 0;

    // Recognised lamp patterns
    localparam logic [LUZ_W-1:0] PAD_CARRO   = 5'b00110;
    localparam logic [LUZ_W-1:0] PAD_PED     = 5'b10001;
    localparam logic [LUZ_W-1:0] PAD_LIMPA_A = 5'b10000;
    localparam logic [LUZ_W-1:0] PAD_LIMPA_B = 5'b10010;
    localparam logic [LUZ_W-1:0] PAD_PISCA_A = 5'b00000;
    localparam logic [LUZ_W-1:0] PAD_PISCA_B = 5'b01000;

    typedef enum logic [FASE_W-1:0] {
        FASE_INIT  = 3'b000,
        FASE_CARRO = 3'b001,
        FASE_PED   = 3'b010,
        FASE_LIMPA = 3'b011,
        FASE_PISCA = 3'b100
    } fase_t;

    // Lower code = higher priority when several errors coincide
    typedef enum logic [ERRO_W-1:0] {
        ERR_NONE      = 3'b000,
        ERR_CONFLITO  = 3'b001,
        ERR_ILEGAL    = 3'b010,
        ERR_TRANSICAO = 3'b011,
        ERR_TIMEOUT   = 3'b100,
        ERR_SEM_PISCA = 3'b101
    } erro_t;

    // Allowed phase sequence: CARRO -> PED -> LIMPA -> CARRO, anything -> PISCA -> CARRO
    function automatic logic transicao_legal(input fase_t de, input fase_t para);
        logic ok;
        ok = 1'b0;
        if (de == FASE_INIT || para == FASE_PISCA || de == para) begin
            ok = 1'b1;
        end else begin
            case (de)
                FASE_CARRO: ok = (para == FASE_PED);
                FASE_PED:   ok = (para == FASE_LIMPA);
                FASE_LIMPA: ok = (para == FASE_CARRO);
                FASE_PISCA: ok = (para == FASE_CARRO);
                default:    ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/semaforo_monitor_if.sv
// Light bus plus monitor status outputs; master = controller/bench side, slave = monitor.
interface semaforo_monitor_if #(
    parameter int unsigned CONT_W = 5
);
    import semaforo_pkg::*;

    logic [LUZ_W-1:0]  saida_in;
    logic              limpa;
    logic [FASE_W-1:0] fase;
    logic              fase_fim;
    logic [CONT_W-1:0] ciclos;
    logic              erro;
    logic [ERRO_W-1:0] cod_erro;

    modport master (
        output saida_in, limpa,
        input  fase, fase_fim, ciclos, erro, cod_erro
    );

    modport slave (
        input  saida_in, limpa,
        output fase, fase_fim, ciclos, erro, cod_erro
    );

endinterface

// File: rtl/semaforo_classif.sv
// Combinational decoder: lamp pattern -> phase class, conflict or illegal flag.
module semaforo_classif
    import semaforo_pkg::*;
(
    input  logic [LUZ_W-1:0] padrao,
    output fase_t            classe_c,
    output logic             conflito_c,
    output logic             ilegal_c
);

    // Exact patterns first; anything else is a conflict if the ped green is lit unsafely
    always_comb begin
        classe_c   = FASE_INIT;
        conflito_c = 1'b0;
        ilegal_c   = 1'b0;
        case (padrao)
            PAD_CARRO:                classe_c = FASE_CARRO;
            PAD_PED:                  classe_c = FASE_PED;
            PAD_LIMPA_A, PAD_LIMPA_B: classe_c = FASE_LIMPA;
            PAD_PISCA_A, PAD_PISCA_B: classe_c = FASE_PISCA;
            default: begin
                if (padrao[PED_VERDE] &&
                    (padrao[CARRO_VERDE] || padrao[CARRO_AMAR] || !padrao[CARRO_VERM]))
                    conflito_c = 1'b1;
                else
                    ilegal_c = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/semaforo_monitor.sv
// Passive checker of the light bus: phase tracking, phase lengths and sticky error reporting.
module semaforo_monitor
    import semaforo_pkg::*;
#(
    parameter int unsigned MAX_FASE = 15,
    parameter int unsigned MAX_FIXO = 2,
    parameter int unsigned CONT_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    semaforo_monitor_if.slave  mon
);

    fase_t             classe_c;
    logic              conflito_c;
    logic              ilegal_c;

    fase_t             fase_q, fase_d;
    logic [CONT_W-1:0] cnt_q, cnt_d;
    logic [CONT_W-1:0] fixo_q, fixo_d;
    logic              to_q, to_d;
    logic              nb_q, nb_d;
    logic [LUZ_W-1:0]  prev_q;
    logic              fim_q, fim_d;
    logic [CONT_W-1:0] ciclos_q, ciclos_d;
    logic              erro_q, erro_d;
    erro_t             cod_q, cod_d;
    erro_t             err_c;

    semaforo_classif u_classif (
        .padrao     (mon.saida_in),
        .classe_c   (classe_c),
        .conflito_c (conflito_c),
        .ilegal_c   (ilegal_c)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fase_q   <= FASE_INIT;
            cnt_q    <= '0;
            fixo_q   <= '0;
            to_q     <= 1'b0;
            nb_q     <= 1'b0;
            prev_q   <= '0;
            fim_q    <= 1'b0;
            ciclos_q <= '0;
            erro_q   <= 1'b0;
            cod_q    <= ERR_NONE;
        end else begin
            fase_q   <= fase_d;
            cnt_q    <= cnt_d;
            fixo_q   <= fixo_d;
            to_q     <= to_d;
            nb_q     <= nb_d;
            prev_q   <= mon.saida_in;
            fim_q    <= fim_d;
            ciclos_q <= ciclos_d;
            erro_q   <= erro_d;
            cod_q    <= cod_d;
        end
    end

    // Next phase, counters, error detection and sticky error update
    always_comb begin
        fase_d   = fase_q;
        cnt_d    = cnt_q;
        fixo_d   = fixo_q;
        to_d     = to_q;
        nb_d     = nb_q;
        fim_d    = 1'b0;
        ciclos_d = ciclos_q;
        erro_d   = erro_q;
        cod_d    = cod_q;
        err_c    = ERR_NONE;

        if (conflito_c || ilegal_c) begin
            fase_d = FASE_INIT;
            cnt_d  = '0;
            fixo_d = '0;
            to_d   = 1'b0;
            nb_d   = 1'b0;
            err_c  = conflito_c ? ERR_CONFLITO : ERR_ILEGAL;
        end else if (classe_c != fase_q) begin
            // Resync to the new class even when the transition is illegal
            fase_d = classe_c;
            cnt_d  = CONT_W'(1);
            fixo_d = CONT_W'(1);
            to_d   = 1'b0;
            nb_d   = 1'b0;
            if (!transicao_legal(fase_q, classe_c))
                err_c = ERR_TRANSICAO;
        end else begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CONT_W'(1);
            if (fase_q != FASE_PISCA && !to_q && cnt_q >= CONT_W'(MAX_FASE)) begin
                err_c = ERR_TIMEOUT;
                to_d  = 1'b1;
            end
            if (fase_q == FASE_LIMPA) begin
                if (mon.saida_in == prev_q) begin
                    fixo_d = (fixo_q == '1) ? fixo_q : fixo_q + CONT_W'(1);
                    if (!nb_q && fixo_q >= CONT_W'(MAX_FIXO)) begin
                        nb_d = 1'b1;
                        if (err_c == ERR_NONE)
                            err_c = ERR_SEM_PISCA;
                    end
                end else begin
                    fixo_d = CONT_W'(1);
                end
            end
        end

        // Report the end of every real phase, including one cut short by an error
        if (fase_d != fase_q && fase_q != FASE_INIT) begin
            fim_d    = 1'b1;
            ciclos_d = cnt_q;
        end

        // First error sticks; a clear in the same cycle as a new error lets the new one in
        if (err_c != ERR_NONE) begin
            if (!erro_q || mon.limpa) begin
                erro_d = 1'b1;
                cod_d  = err_c;
            end
        end else if (mon.limpa) begin
            erro_d = 1'b0;
            cod_d  = ERR_NONE;
        end
    end

    assign mon.fase     = fase_q;
    assign mon.fase_fim = fim_q;
    assign mon.ciclos   = ciclos_q;
    assign mon.erro     = erro_q;
    assign mon.cod_erro = cod_q;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Directed scoreboard bench for semaforo_monitor.
module tb_semaforo_monitor;
    import semaforo_pkg::*;

    typedef struct packed {
        logic [2:0] fase;
        logic       fim;
        logic [4:0] ciclos;
        logic       erro;
        logic [2:0] cod;
    } exp_t;

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   passo = 0;
    exp_t fila[$];
    logic [4:0] ec;
    logic       ee;
    logic [2:0] ed;

    semaforo_monitor_if #(.CONT_W(5)) bus ();

    semaforo_monitor #(.MAX_FASE(15), .MAX_FIXO(2), .CONT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .mon (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s step %0d: observed %0h expected %0h", tag, passo, obs, expv);
        end
    endtask

    // Drive one sample and queue what the outputs must show after the next edge
    task automatic cyc(input logic [4:0] p, input logic l, input logic [2:0] f, input logic fim);
        exp_t e;
        @(negedge clk);
        bus.saida_in = p;
        bus.limpa    = l;
        e.fase   = f;
        e.fim    = fim;
        e.ciclos = ec;
        e.erro   = ee;
        e.cod    = ed;
        fila.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 5 && fila.size() > 0; i++) @(negedge clk);
        chk("drain", 8'(fila.size()), 8'd0);
        @(negedge clk);
        bus.limpa = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_fase"},   8'(bus.fase),     8'd0);
        chk({tag, "_fim"},    8'(bus.fase_fim), 8'd0);
        chk({tag, "_ciclos"}, 8'(bus.ciclos),   8'd0);
        chk({tag, "_erro"},   8'(bus.erro),     8'd0);
        chk({tag, "_cod"},    8'(bus.cod_erro), 8'd0);
    endtask

    // Scoreboard: pop one expectation per edge while stimulus is pending
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (fila.size() > 0) begin
            e = fila.pop_front();
            passo++;
            chk("fase",     8'(bus.fase),     8'(e.fase));
            chk("fase_fim", 8'(bus.fase_fim), 8'(e.fim));
            chk("ciclos",   8'(bus.ciclos),   8'(e.ciclos));
            chk("erro",     8'(bus.erro),     8'(e.erro));
            chk("cod_erro", 8'(bus.cod_erro), 8'(e.cod));
        end
    end

    initial begin
        rst          = 1'b0;
        bus.saida_in = PAD_CARRO;
        bus.limpa    = 1'b0;
        ec = '0; ee = 1'b0; ed = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #2;
        rst = 1'b1;

        // Normal cycle CARRO -> PED -> LIMPA (blinking) -> CARRO
        repeat (7) cyc(PAD_CARRO, 1'b0, 3'd1, 1'b0);
        ec = 5'd7;
        cyc(PAD_PED, 1'b0, 3'd2, 1'b1);
        repeat (4) cyc(PAD_PED, 1'b0, 3'd2, 1'b0);
        ec = 5'd5;
        cyc(PAD_LIMPA_B, 1'b0, 3'd3, 1'b1);
        cyc(PAD_LIMPA_A, 1'b0, 3'd3, 1'b0);
        cyc(PAD_LIMPA_B, 1'b0, 3'd3, 1'b0);
        cyc(PAD_LIMPA_A, 1'b0, 3'd3, 1'b0);
        cyc(PAD_LIMPA_B, 1'b0, 3'd3, 1'b0);
        cyc(PAD_CARRO, 1'b0, 3'd1, 1'b1);

        // Conflict, then clear
        ec = 5'd1; ee = 1'b1; ed = 3'd1;
        cyc(5'b00101, 1'b0, 3'd0, 1'b1);
        ee = 1'b0; ed = 3'd0;
        cyc(PAD_CARRO, 1'b1, 3'd1, 1'b0);
        repeat (2) cyc(PAD_CARRO, 1'b0, 3'd1, 1'b0);

        // Illegal transition resyncs; later conflict does not overwrite the code
        ec = 5'd3; ee = 1'b1; ed = 3'd3;
        cyc(PAD_LIMPA_A, 1'b0, 3'd3, 1'b1);
        ec = 5'd1;
        cyc(5'b00101, 1'b0, 3'd0, 1'b1);
        // New illegal pattern together with clear: new code wins
        ed = 3'd2;
        cyc(5'b11000, 1'b1, 3'd0, 1'b0);
        ee = 1'b0; ed = 3'd0;
        cyc(PAD_CARRO, 1'b1, 3'd1, 1'b0);

        // Timeout on the 16th CARRO sample, once only; counter saturates at 31
        repeat (14) cyc(PAD_CARRO, 1'b0, 3'd1, 1'b0);
        ee = 1'b1; ed = 3'd4;
        cyc(PAD_CARRO, 1'b0, 3'd1, 1'b0);
        ee = 1'b0; ed = 3'd0;
        cyc(PAD_CARRO, 1'b1, 3'd1, 1'b0);
        repeat (18) cyc(PAD_CARRO, 1'b0, 3'd1, 1'b0);
        ec = 5'd31;
        cyc(PAD_PED, 1'b0, 3'd2, 1'b1);

        // LIMPA without blinking: error on the 3rd identical sample, once only
        ec = 5'd1;
        cyc(PAD_LIMPA_A, 1'b0, 3'd3, 1'b1);
        cyc(PAD_LIMPA_A, 1'b0, 3'd3, 1'b0);
        ee = 1'b1; ed = 3'd5;
        cyc(PAD_LIMPA_A, 1'b0, 3'd3, 1'b0);
        ee = 1'b0; ed = 3'd0;
        cyc(PAD_LIMPA_A, 1'b1, 3'd3, 1'b0);
        ec = 5'd4;
        cyc(PAD_CARRO, 1'b0, 3'd1, 1'b1);

        // Flashing from CARRO, longer than the steady timeout, then back to CARRO
        ec = 5'd1;
        cyc(PAD_PISCA_B, 1'b0, 3'd4, 1'b1);
        for (int i = 1; i < 20; i++)
            cyc((i % 2 == 1) ? PAD_PISCA_A : PAD_PISCA_B, 1'b0, 3'd4, 1'b0);
        ec = 5'd20;
        cyc(PAD_CARRO, 1'b0, 3'd1, 1'b1);
        cyc(PAD_CARRO, 1'b0, 3'd1, 1'b0);
        drain();

        // Asynchronous reset mid-phase, then clean entry from INIT
        #2;
        rst = 1'b0;
        #1;
        chk_zero("async_rst");
        @(posedge clk); #2;
        rst = 1'b1;
        ec = '0; ee = 1'b0; ed = '0;
        cyc(PAD_PED, 1'b0, 3'd2, 1'b0);
        cyc(PAD_PED, 1'b0, 3'd2, 1'b0);
        ec = 5'd2;
        cyc(PAD_LIMPA_B, 1'b0, 3'd3, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/semaforo_monitor.md
Name: semaforo_monitor

Overview:
Passive checker on the 5-bit traffic/pedestrian light bus driven by the light controller. It decodes the lamp pattern into a phase and measures each phase's length in cycles. It flags unsafe or illegal patterns, illegal phase orderings, stuck phases and missing pedestrian blink. It sits beside the controller in the top level and feeds the status/debug LEDs and testbench scoreboards.

Parameters:
MAX_FASE, 15, maximum consecutive cycles allowed in a steady phase (CARRO, PED, LIMPA) before timeout
MAX_FIXO, 2, maximum consecutive identical samples allowed in LIMPA before a no-blink error
CONT_W, 5, width of the phase cycle counter (saturating)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
saida_in  input  5  light bus: [4] car red, [3] car yellow, [2] car green, [1] ped red, [0] ped green
limpa  input  1  one-cycle pulse, clears sticky error
fase  output  3  current decoded phase
fase_fim  output  1  one-cycle pulse: a phase just ended
ciclos  output  CONT_W  length in cycles of the phase that just ended; valid while fase_fim=1, held otherwise
erro  output  1  sticky error flag
cod_erro  output  3  code of first error since last clear

Behaviour:
- Reset (rst=0, async): fase=INIT(000), fase_fim=0, ciclos=0, erro=0, cod_erro=000, counters and previous-sample register cleared.
- Classification of saida_in (combinational, each cycle):
  - 00110 -> CARRO(001).
  - 10001 -> PED(010).
  - 10000 or 10010 -> LIMPA(011).
  - 00000 or 01000 -> PISCA(100).
  - Any pattern with bit0=1 and (bit2|bit3|~bit4) -> CONFLITO.
  - All other patterns -> ILEGAL.
- Latency: fase reflects saida_in sampled at the previous rising edge (1 cycle).
- Legal transitions:
  - INIT -> any recognised class.
  - CARRO -> PED -> LIMPA -> CARRO.
  - Any -> PISCA.
  - PISCA -> CARRO.
  - Same class -> same class (phase continues).
- Error codes:
  - 001 CONFLITO: fase -> INIT.
  - 010 ILEGAL: fase -> INIT.
  - 011 illegal transition: fase still takes the new class (resync).
  - 100 timeout: steady phase counter would exceed MAX_FASE. Flag once per phase occurrence; fase unchanged.
  - 101 no-blink: in LIMPA, saida_in equal to previous sample for more than MAX_FIXO consecutive cycles. Flag once per LIMPA occurrence.
- Counter:
  - Counts cycles in the current phase, saturating at 2^CONT_W-1.
  - Reloads to 1 on a phase change.
  - PISCA has no timeout.
- fase_fim: on any phase change other than out of INIT, fase_fim=1 for exactly one cycle, with ciclos = count of the finished phase.
- Sticky error:
  - erro=1 and cod_erro latched on the first error; later errors do not overwrite cod_erro.
  - limpa=1 clears both. limpa and a new error in the same cycle: the new error wins (erro=1, cod_erro=new code).
- Multiple errors in one cycle: priority 001 > 010 > 011 > 100 > 101.
- Reset mid-phase: everything returns to reset values immediately; the first recognised pattern afterwards enters from INIT without error.

Decomposition:
- Package semaforo_pkg holds:
  - phase codes INIT/CARRO/PED/LIMPA/PISCA;
  - error codes;
  - light bit indices (CARRO_VERM=4 … PED_VERDE=0);
  - the recognised 5-bit patterns as constants.
- Sub-module semaforo_classif: combinational pattern -> {class, conflito, ilegal} decoder, instanced once. The monitor holds the FSM, counters and sticky error.

Test Plan:
- 7 cycles of 00110 then 10001 -> fase 001 then 010; fase_fim pulse with ciclos=7; erro=0.
- Full cycle: 00110×7, 10001×5, then 10010/10000 alternating ×5, then 00110 -> fases 001,010,011,001; no error.
- 00110 then 00101 -> erro=1, cod_erro=001, fase=000. Pulse limpa -> erro=0, cod_erro=000.
- 00110×3 then 10000 -> cod_erro=011, fase=011.
- 00110 held 16 cycles -> erro rises on 16th sample, cod_erro=100. Separately, 10000 held 3 cycles in LIMPA -> cod_erro=101.
- 01000/00000 alternating 10 cycles from CARRO -> fase=100, no error. Then 00110 -> fase=001. Drive rst=0 mid-phase -> all outputs 0 without waiting for clk.
